// File: rtl/booth_pkg.sv
// Shared types and saturation helpers for the Booth-multiplier MAC back end.
package booth_pkg;

    localparam int DATAWIDTH = 10;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Clamp limits of a w-bit two's complement accumulator.
    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/booth_sat_add.sv
// Combinational W-bit signed saturating adder: one guard bit, clamp on overflow.
module booth_sat_add
    import booth_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_sat
);

    localparam logic [W-1:0] MAXV = W'(sat_max(W));
    localparam logic [W-1:0] MINV = W'(sat_min(W));

    logic [W:0] w_full;

    assign w_full = {i_a[W-1], i_a} + {i_b[W-1], i_b};

    // Guard bit disagreeing with the top bit means the true sum left the range.
    always_comb begin
        o_sum = w_full[W-1:0];
        o_sat = 1'b0;
        if (w_full[W] != w_full[W-1]) begin
            o_sat = 1'b1;
            o_sum = w_full[W] ? MINV : MAXV;
        end
    end

endmodule

// File: rtl/booth_acc.sv
// Accumulates LEN Booth products per group into a saturating sum and
// presents each finished sum on a valid/ready port.
module booth_acc
    import booth_pkg::*;
#(
    parameter int DATAWIDTH = booth_pkg::DATAWIDTH,
    parameter int PWIDTH    = 2 * DATAWIDTH,
    parameter int ACC_WIDTH = 24,
    parameter int LEN       = 4,
    parameter int CNTW      = $clog2(LEN) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 done_in,
    input  logic [PWIDTH-1:0]    product_in,
    output logic                 in_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic                 acc_valid,
    input  logic                 acc_ready,
    output logic                 sat_flag,
    output logic                 drop_err,
    output logic [CNTW-1:0]      term_cnt
);

    state_t r_state, w_state_nxt;

    logic                 r_done_d;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_acc_out;
    logic                 r_valid;
    logic                 r_satf;
    logic                 r_drop;
    logic                 r_sat;
    logic [CNTW-1:0]      r_term;

    logic                 w_cap;
    logic                 w_last;
    logic                 w_accept;
    logic                 w_hs;
    logic                 w_drop;
    logic                 w_in_ready;
    logic [ACC_WIDTH-1:0] w_pext;
    logic [ACC_WIDTH-1:0] w_sum;
    logic                 w_clamp;

    assign w_cap  = done_in & ~r_done_d;
    assign w_last = (r_term == CNTW'(LEN - 1));
    assign w_pext = ACC_WIDTH'($signed(product_in));

    // In HOLD r_acc/r_term/r_sat are already zero, so a product accepted
    // alongside the handshake naturally starts a fresh group.
    booth_sat_add #(.W(ACC_WIDTH)) u_add (
        .i_a   (r_acc),
        .i_b   (w_pext),
        .o_sum (w_sum),
        .o_sat (w_clamp)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        w_hs        = 1'b0;
        w_accept    = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_ACC: begin
                w_accept = w_cap;
                if (w_cap && w_last) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_in_ready = acc_ready;
                w_hs       = r_valid & acc_ready;
                w_accept   = w_cap & w_hs;
                w_drop     = w_cap & ~w_hs;
                if (w_hs && !(w_accept && w_last)) w_state_nxt = ST_ACC;
            end
            default: w_state_nxt = ST_ACC;
        endcase
        if (clr) w_state_nxt = ST_ACC;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_ACC;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_done_d  <= 1'b1;
            r_acc     <= '0;
            r_acc_out <= '0;
            r_valid   <= 1'b0;
            r_satf    <= 1'b0;
            r_drop    <= 1'b0;
            r_sat     <= 1'b0;
            r_term    <= '0;
        end else begin
            r_done_d <= done_in;
            if (clr) begin
                r_acc   <= '0;
                r_term  <= '0;
                r_sat   <= 1'b0;
                r_valid <= 1'b0;
                r_satf  <= 1'b0;
                r_drop  <= 1'b0;
            end else begin
                if (w_drop) r_drop <= 1'b1;
                if (w_hs) begin
                    r_valid <= 1'b0;
                    r_satf  <= 1'b0;
                end
                if (w_accept) begin
                    if (w_last) begin
                        r_acc_out <= w_sum;
                        r_valid   <= 1'b1;
                        r_satf    <= r_sat | w_clamp;
                        r_acc     <= '0;
                        r_term    <= '0;
                        r_sat     <= 1'b0;
                    end else begin
                        r_acc  <= w_sum;
                        r_term <= r_term + CNTW'(1);
                        r_sat  <= r_sat | w_clamp;
                    end
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign acc_out   = r_acc_out;
    assign acc_valid = r_valid;
    assign sat_flag  = r_satf;
    assign drop_err  = r_drop;
    assign term_cnt  = r_term;

endmodule
